conv_row_feeder: RTL and testbench
==================================

// Module: conv_row_feeder
// PURPOSE
//  Upstream stage of the convolution engine. Packs a raster 8-bit pixel stream
//  into 256-bit row-segment words (32 px) and buffers them in a small FIFO.
//  Serves each word to the engine's 256-bit data input on the engine's request
//  line, tracks row/frame position and flags frame completion.
// PARAMETERS
//  width       1920  pixels per image row
//  height      1080  rows per frame
//  FIFO_DEPTH  4     buffered 256-bit words; power of 2, >=2
// PORTS
//  clk         in   1    single clock, rising edge
//  reset       in   1    asynchronous, active-low
//  iPixel      in   8    input pixel, raster order
//  iPixValid   in   1    iPixel valid this cycle
//  oPixReady   out  1    pixel accepted when iPixValid && oPixReady
//  iReq        in   1    engine request (driven by engine oReq), level
//  oData       out  256  packed word; pixel 0 at [255:248], pixel 31 at [7:0]
//  oValid      out  1    oData valid, one-cycle pulse per word
//  oRowEnd     out  1    qualifies oValid: word is last of its row
//  oDone       out  1    one-cycle pulse: whole frame delivered
// BEHAVIOUR
//  - Reset (reset==0): oData=0, oValid=0, oRowEnd=0, oDone=0, oPixReady=0;
//    FIFO empty, counters 0, state RUN. Async assert; release sync to clk.
//  - Packing: lane counter 0..31; accepted pixel k goes to [255-8k:248-8k].
//    Word pushed to FIFO when lane 31 written OR last pixel of a row.
//    Partial last word (width%32!=0): unused lanes forced to 0.
//    Words per row = ceil(width/32) (60 for 1920). Row-end bit stored with word.
//  - oPixReady = (state==RUN) && !fifo_full. Conservative: deasserts whenever
//    FIFO full, even if current pixel would not complete a word.
//  - Pop: any cycle with iReq==1 && !fifo_empty pops one word; next cycle
//    oValid=1 with that oData/oRowEnd (1-cycle latency). iReq while empty:
//    no pop, no response, request not remembered. oData holds last value
//    when oValid==0.
//  - Push and pop in same cycle: occupancy unchanged; allowed when full
//    (pop frees slot same cycle is NOT used; push still gated by !full).
//  - Column counter 0..width-1, row counter 0..height-1, wrap at row end.
//  - FSM:
//    RUN   : accept pixels. On accept of pixel (width-1, height-1) -> DRAIN.
//    DRAIN : oPixReady=0. When FIFO empty and no oValid pending -> DONE.
//    DONE  : oDone=1 for exactly one cycle; counters cleared -> RUN.
//  - oDone cycle is after the final oValid cycle (never coincident).
//  - reset mid-frame: FIFO and partial word discarded, no oDone.
// CONFIGURATION
//  FEEDER_STALL_CNT_EN defined: adds output oStallCnt [31:0] counting cycles
//   with iReq==1 && fifo_empty && state!=DONE; saturates at 32'hFFFFFFFF;
//   cleared by reset and on the DONE cycle (value before clear is valid
//   during the oDone pulse). Undefined: port and counter absent, no logic.
// TESTING (bench params width=64, height=2, FIFO_DEPTH=4 unless noted)
//  1 Pixels 0..63 row0, 64..127 row1, iReq held 1 -> 4 words; word0[255:248]
//    =0x00, [7:0]=0x1F; oRowEnd on words 1,3; oDone 1 cycle after last oValid.
//  2 width=40,height=1, pixels 1..40 -> word0 px1..32; word1 [255:192]=px33..40,
//    [191:0]=0, oRowEnd=1 on word1 only.
//  3 iReq=0, stream 128 px -> oPixReady drops after 4th push (FIFO full);
//    raise iReq -> ready returns, all 4 words out in order, no loss/duplication.
//  4 iReq pulsed 1 cycle with FIFO empty -> no oValid; later word served only
//    on a subsequent iReq.
//  5 Assert reset after 40 px of frame -> outputs 0 immediately; after release
//    full 128-px frame produces exactly 4 words and one oDone.
//  6 FEEDER_STALL_CNT_EN: iReq=1 for 10 cycles before first word completes ->
//    oStallCnt=10 during oDone pulse (no other stalls), 0 the cycle after.

Source files
------------

// File: rtl/conv_row_feeder_if.sv
// Pixel-stream and engine-side signals of conv_row_feeder.
// FEEDER_STALL_CNT_EN adds the oStallCnt observation output.
interface conv_row_feeder_if;
  logic [7:0]   iPixel;
  logic         iPixValid;
  logic         oPixReady;
  logic         iReq;
  logic [255:0] oData;
  logic         oValid;
  logic         oRowEnd;
  logic         oDone;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]  oStallCnt;

  modport master (output iPixel, iPixValid, iReq,
                  input  oPixReady, oData, oValid, oRowEnd, oDone, oStallCnt);
  modport slave  (input  iPixel, iPixValid, iReq,
                  output oPixReady, oData, oValid, oRowEnd, oDone, oStallCnt);
`else
  modport master (output iPixel, iPixValid, iReq,
                  input  oPixReady, oData, oValid, oRowEnd, oDone);
  modport slave  (input  iPixel, iPixValid, iReq,
                  output oPixReady, oData, oValid, oRowEnd, oDone);
`endif
endinterface

// File: rtl/conv_row_feeder.sv
// Packs raster 8-bit pixels into 256-bit row-segment words, buffers them in a
// small FIFO and serves them on engine request. Option: FEEDER_STALL_CNT_EN.
module conv_row_feeder #(
  parameter int width      = 1920,
  parameter int height     = 1080,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  conv_row_feeder_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam int RW = (height > 1) ? $clog2(height) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [255:0]    pack_reg, pack_next;
  logic [4:0]      lane_reg;
  logic [CW-1:0]   col_reg;
  logic [RW-1:0]   row_reg;
  logic [256:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [255:0]    data_reg;
  logic            valid_reg, row_end_reg, done_reg, ready_reg;

  logic            accept, last_col, last_row, push, pop;
  logic            fifo_empty, fifo_full;

  always_comb begin
    accept     = bus.iPixValid && ready_reg;
    last_col   = (col_reg == CW'(width - 1));
    last_row   = (row_reg == RW'(height - 1));
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == FULL_CNT);
    // ready already excludes a full FIFO, so every completed word has a slot
    push       = accept && ((lane_reg == 5'd31) || last_col);
    pop        = bus.iReq && !fifo_empty;

    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    pack_next = pack_reg;
    if (accept)
      pack_next[8 * (31 - int'(lane_reg)) +: 8] = bus.iPixel;

    state_next = state_reg;
    case (state_reg)
      RUN:     if (accept && last_col && last_row) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Storage has no reset so it maps onto RAM; lanes beyond the row end are
  // already zero because the packer clears after every push.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {last_col, pack_next};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= RUN;
      pack_reg    <= '0;
      lane_reg    <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      row_end_reg <= 1'b0;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ready_reg <= (state_next == RUN) && (count_next != FULL_CNT);
      done_reg  <= (state_reg == DRAIN) && (state_next == DONE);
      valid_reg <= pop;

      if (pop) begin
        {row_end_reg, data_reg} <= mem[rd_ptr_reg];
        rd_ptr_reg              <= rd_ptr_reg + 1'b1;
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;

      if (push) begin
        pack_reg <= '0;
        lane_reg <= '0;
      end else begin
        pack_reg <= pack_next;
        if (accept)
          lane_reg <= lane_reg + 1'b1;
      end

      if (state_reg == DONE) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_reg <= '0;
          row_reg <= last_row ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  assign bus.oPixReady = ready_reg;
  assign bus.oData     = data_reg;
  assign bus.oValid    = valid_reg;
  assign bus.oRowEnd   = row_end_reg;
  assign bus.oDone     = done_reg;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Held through the DONE cycle so the total is readable alongside oDone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_reg <= '0;
    else if (state_reg == DONE)
      stall_cnt_reg <= '0;
    else if (bus.iReq && fifo_empty && (stall_cnt_reg != 32'hFFFF_FFFF))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign bus.oStallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_conv_row_feeder.sv
// Directed bench for conv_row_feeder: a 64x2 instance for framing, flow
// control and reset, and a 40x1 instance for the partial-word case.
`timescale 1ns/1ps
module tb_conv_row_feeder;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  conv_row_feeder_if a_if();
  conv_row_feeder_if b_if();

  conv_row_feeder #(.width(64), .height(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(a_if)
  );
  conv_row_feeder #(.width(40), .height(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(b_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int timeouts = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorders; the main sequence only reads these.
  logic [255:0] a_words[$];
  logic         a_rend[$];
  int           a_vcyc[$];
  int           a_dones = 0;
  int           a_done_cyc = 0;
  logic [255:0] b_words[$];
  logic         b_rend[$];
  int           b_dones = 0;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]  a_stall_at_done = 32'hDEAD_BEEF;
  logic [31:0]  a_stall_after = 32'hDEAD_BEEF;
  logic         a_prev_done = 1'b0;
`endif

  always @(negedge clk) begin
    if (a_if.oValid) begin
      a_words.push_back(a_if.oData);
      a_rend.push_back(a_if.oRowEnd);
      a_vcyc.push_back(cyc);
      $display("A word %0d: data=%h rowend=%0b", a_words.size() - 1, a_if.oData, a_if.oRowEnd);
    end
    if (a_if.oDone) begin
      a_dones++;
      a_done_cyc = cyc;
    end
    if (b_if.oValid) begin
      b_words.push_back(b_if.oData);
      b_rend.push_back(b_if.oRowEnd);
      $display("B word %0d: data=%h rowend=%0b", b_words.size() - 1, b_if.oData, b_if.oRowEnd);
    end
    if (b_if.oDone) b_dones++;
`ifdef FEEDER_STALL_CNT_EN
    if (a_if.oDone) a_stall_at_done = a_if.oStallCnt;
    if (a_prev_done) a_stall_after = a_if.oStallCnt;
    a_prev_done = a_if.oDone;
`endif
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_word(input int base, input int n);
    logic [255:0] w = '0;
    for (int k = 0; k < n; k++) w[255 - 8 * k -: 8] = 8'(base + k);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drives n pixels base, base+1, ... waiting (bounded) on ready each time.
  task automatic send_px(input bit sel, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (!(sel ? b_if.oPixReady : a_if.oPixReady) && g < 400) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 400) begin
        timeouts++;
        break;
      end
      if (sel) begin
        b_if.iPixel = 8'(base + i);
        b_if.iPixValid = 1'b1;
      end else begin
        a_if.iPixel = 8'(base + i);
        a_if.iPixValid = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    a_if.iPixValid = 1'b0;
    b_if.iPixValid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int prev);
    int g = 0;
    while ((sel ? b_dones : a_dones) == prev && g < 600) begin
      @(negedge clk);
      #1;
      g++;
    end
  endtask

  int bw, bd;

  initial begin
    a_if.iPixel = '0; a_if.iPixValid = 1'b0; a_if.iReq = 1'b0;
    b_if.iPixel = '0; b_if.iPixValid = 1'b0; b_if.iReq = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(3);

    check("rst_data",  a_if.oData, 256'd0);
    check("rst_valid", a_if.oValid, 1'b0);
    check("rst_rowend", a_if.oRowEnd, 1'b0);
    check("rst_done",  a_if.oDone, 1'b0);
    check("rst_ready", a_if.oPixReady, 1'b0);
    check("rst_b_ready", b_if.oPixReady, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(2);

    // Full 64x2 frame with the engine always requesting
    a_if.iReq = 1'b1;
    bw = a_words.size(); bd = a_dones;
    send_px(0, 0, 128);
    wait_done(0, bd);
    idle(2);
    check("t1_nwords", a_words.size() - bw, 4);
    if (a_words.size() - bw >= 4) begin
      check("t1_w0_msb", a_words[bw][255:248], 8'h00);
      check("t1_w0_lsb", a_words[bw][7:0], 8'h1F);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t1_word%0d", k), a_words[bw + k], exp_word(32 * k, 32));
        check($sformatf("t1_rowend%0d", k), a_rend[bw + k], (k % 2 == 1) ? 1'b1 : 1'b0);
      end
      check("t1_done_lat", a_done_cyc - a_vcyc[bw + 3], 1);
    end
    check("t1_ndone", a_dones - bd, 1);

    // Request while empty is dropped; a buffered word waits for a new request
    a_if.iReq = 1'b0;
    idle(2);
    bw = a_words.size();
    a_if.iReq = 1'b1;
    idle(1);
    a_if.iReq = 1'b0;
    idle(5);
    check("t4_empty_req", a_words.size() - bw, 0);
    send_px(0, 'h80, 32);
    idle(5);
    check("t4_no_req", a_words.size() - bw, 0);
    a_if.iReq = 1'b1;
    idle(1);
    a_if.iReq = 1'b0;
    idle(3);
    check("t4_one_word", a_words.size() - bw, 1);
    if (a_words.size() - bw >= 1)
      check("t4_word", a_words[bw], exp_word('h80, 32));

    // Reset mid-frame, 40 pixels in with a partial word pending
    send_px(0, 'h90, 8);
    #2;
    bd = a_dones;
    rst_a = 1'b0;
    #1;
    check("t5_data",  a_if.oData, 256'd0);
    check("t5_valid", a_if.oValid, 1'b0);
    check("t5_done",  a_if.oDone, 1'b0);
    check("t5_ready", a_if.oPixReady, 1'b0);
    idle(2);
    rst_a = 1'b1;
    idle(2);

    // Fresh frame with no requests fills the FIFO, then drains in order
    a_if.iReq = 1'b0;
    bw = a_words.size();
    send_px(0, 'h40, 128);
    idle(3);
    check("t3_ready_low", a_if.oPixReady, 1'b0);
    check("t3_no_out", a_words.size() - bw, 0);
    a_if.iReq = 1'b1;
    wait_done(0, bd);
    a_if.iReq = 1'b0;
    idle(3);
    check("t3_nwords", a_words.size() - bw, 4);
    if (a_words.size() - bw >= 4) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("t3_word%0d", k), a_words[bw + k], exp_word('h40 + 32 * k, 32));
      check("t3_rowend3", a_rend[bw + 3], 1'b1);
    end
    check("t3_ndone", a_dones - bd, 1);
    check("t3_ready_back", a_if.oPixReady, 1'b1);

    // 40x1 frame: second word is partial and zero-filled
    b_if.iReq = 1'b1;
    bw = b_words.size(); bd = b_dones;
    send_px(1, 1, 40);
    wait_done(1, bd);
    b_if.iReq = 1'b0;
    idle(2);
    check("t2_nwords", b_words.size() - bw, 2);
    if (b_words.size() - bw >= 2) begin
      check("t2_word0", b_words[bw], exp_word(1, 32));
      check("t2_word1_hi", b_words[bw + 1][255:192], 64'h2122_2324_2526_2728);
      check("t2_word1_lo", b_words[bw + 1][191:0], 192'd0);
      check("t2_rowend0", b_rend[bw], 1'b0);
      check("t2_rowend1", b_rend[bw + 1], 1'b1);
    end
    check("t2_ndone", b_dones - bd, 1);

`ifdef FEEDER_STALL_CNT_EN
    // Ten requests against an empty FIFO, none afterwards
    rst_a = 1'b0;
    idle(2);
    rst_a = 1'b1;
    idle(2);
    bd = a_dones;
    a_if.iReq = 1'b1;
    repeat (10) @(negedge clk);
    a_if.iReq = 1'b0;
    #1;
    send_px(0, 0, 128);
    idle(2);
    a_if.iReq = 1'b1;
    repeat (4) @(negedge clk);
    a_if.iReq = 1'b0;
    #1;
    wait_done(0, bd);
    idle(3);
    check("t6_ndone", a_dones - bd, 1);
    check("t6_stall_at_done", a_stall_at_done, 32'd10);
    check("t6_stall_after", a_stall_after, 32'd0);
`endif

    check("ready_timeouts", timeouts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
